// File: rtl/game_pkg.sv
// Shared game definitions: difficulty codes, selection FSM encoding and the
// difficulty stepping helper. Used by difficulty_select, the display and game control.
package game_pkg;

  localparam int unsigned DIFF_W = 2;

  localparam logic [DIFF_W-1:0] DIFF_EASY = 2'b00;
  localparam logic [DIFF_W-1:0] DIFF_HARD = 2'b01;
  localparam logic [DIFF_W-1:0] DIFF_HELL = 2'b10;

  typedef enum logic {
    ST_SELECT = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Cyclic step through EASY -> HARD -> HELL; up=0 steps backwards.
  // The unused code 11 recovers to a legal value in either direction.
  function automatic logic [DIFF_W-1:0] diff_step(input logic [DIFF_W-1:0] d,
                                                   input logic             up);
    logic [DIFF_W-1:0] r;
    r = DIFF_EASY;
    if (up) begin
      case (d)
        DIFF_EASY: r = DIFF_HARD;
        DIFF_HARD: r = DIFF_HELL;
        default:   r = DIFF_EASY;
      endcase
    end else begin
      case (d)
        DIFF_EASY: r = DIFF_HELL;
        DIFF_HARD: r = DIFF_EASY;
        default:   r = DIFF_HARD;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key conditioning: 2-FF synchroniser, stability-counting debouncer and a
// registered one-cycle press detector (filtered 1->0 only).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   key_n      : raw asynchronous active-low button
//   press      : one-cycle pulse, the cycle after the filtered level falls
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             filt;
  logic             filt_d;
  logic [CNT_W-1:0] cnt;

  // Synchroniser; idles released (1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Debouncer: accept a new level only after DEBOUNCE_CYCLES differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else if (sync2 == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      filt <= sync2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Press detector, registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_d <= 1'b1;
      press  <= 1'b0;
    end else begin
      filt_d <= filt;
      press  <= filt_d & ~filt;
    end
  end

endmodule

// File: rtl/difficulty_select.sv
// Difficulty selection control: debounces up/down/confirm buttons, steps the
// difficulty code with wrap-around and locks it on confirm with a start pulse.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   key_up_n, key_down_n,
//   key_confirm_n                   : raw active-low buttons
//   game_over                       : one-cycle pulse, unlocks selection
//   difficulty                      : 00 EASY, 01 HARD, 10 HELL
//   locked                          : selection frozen
//   start_pulse                     : one cycle, first cycle of locked
module difficulty_select
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_up_n,
  input  logic              key_down_n,
  input  logic              key_confirm_n,
  input  logic              game_over,
  output logic [DIFF_W-1:0] difficulty,
  output logic              locked,
  output logic              start_pulse
);

  logic up_p;
  logic dn_p;
  logic cf_p;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key_up (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_up_n),
    .press (up_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key_down (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_down_n),
    .press (dn_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key_confirm (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_confirm_n),
    .press (cf_p)
  );

  state_t            state_q;
  state_t            state_d;
  logic [DIFF_W-1:0] diff_d;
  logic              start_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_SELECT;
      difficulty  <= DIFF_EASY;
      locked      <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      difficulty  <= diff_d;
      locked      <= (state_d == ST_LOCKED);
      start_pulse <= start_d;
    end
  end

  // Next state: confirm beats up/down; simultaneous up+down cancel.
  always_comb begin
    state_d = state_q;
    diff_d  = difficulty;
    start_d = 1'b0;
    case (state_q)
      ST_SELECT: begin
        if (cf_p) begin
          state_d = ST_LOCKED;
          start_d = 1'b1;
        end else if (up_p && !dn_p) begin
          diff_d = diff_step(difficulty, 1'b1);
        end else if (dn_p && !up_p) begin
          diff_d = diff_step(difficulty, 1'b0);
        end
      end
      ST_LOCKED: begin
        if (game_over) begin
          state_d = ST_SELECT;
        end
      end
      default: state_d = ST_SELECT;
    endcase
  end

endmodule

// File: tb/tb_difficulty_select.sv
module tb_difficulty_select;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_up_n;
  logic       key_down_n;
  logic       key_confirm_n;
  logic       game_over;
  logic [1:0] difficulty;
  logic       locked;
  logic       start_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  difficulty_select #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_up_n      (key_up_n),
    .key_down_n    (key_down_n),
    .key_confirm_n (key_confirm_n),
    .game_over     (game_over),
    .difficulty    (difficulty),
    .locked        (locked),
    .start_pulse   (start_pulse)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic up, input logic dn, input logic cf);
    key_up_n      = ~up;
    key_down_n    = ~dn;
    key_confirm_n = ~cf;
  endtask

  // Press the chosen keys long enough to qualify (raw->output is D+3 edges),
  // release and let the debouncers settle back to released.
  task automatic tap(input logic up, input logic dn, input logic cf);
    drive(up, dn, cf);
    tick(D + 4);
    drive(1'b0, 1'b0, 1'b0);
    tick(D + 6);
  endtask

  task automatic check_state(input string tag, input logic [1:0] d, input logic l,
                             input logic s);
    check({tag, ".diff"},  8'(difficulty),  8'(d));
    check({tag, ".lock"},  8'(locked),      8'(l));
    check({tag, ".start"}, 8'(start_pulse), 8'(s));
  endtask

  initial begin
    rst_n     = 1'b0;
    game_over = 1'b0;
    drive(1'b1, 1'b0, 1'b0);

    // Reset with up held; it must be re-qualified after release.
    tick(3);
    check_state("rst_held", 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(D + 3);
    check("rst_requal_early", 8'(difficulty), 8'h00);
    tick(1);
    check("rst_requal", 8'(difficulty), 8'h01);
    drive(1'b0, 1'b0, 1'b0);
    tick(D + 6);
    check("rst_requal_once", 8'(difficulty), 8'h01);

    // Clean reset, keys released.
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check_state("rst", 2'b00, 1'b0, 1'b0);

    // Single clean press held 10 cycles: changes after edge 7 only.
    drive(1'b1, 1'b0, 1'b0);
    tick(7);
    check("clean_edge6", 8'(difficulty), 8'h00);
    tick(1);
    check("clean_edge7", 8'(difficulty), 8'h01);
    tick(2);
    check("clean_held", 8'(difficulty), 8'h01);
    drive(1'b0, 1'b0, 1'b0);
    tick(D + 6);
    check("clean_release", 8'(difficulty), 8'h01);

    // Wrap in both directions.
    tap(1'b1, 1'b0, 1'b0);
    check("up_to_hell", 8'(difficulty), 8'h02);
    tap(1'b1, 1'b0, 1'b0);
    check("up_wrap", 8'(difficulty), 8'h00);
    tap(1'b0, 1'b1, 1'b0);
    check("dn_wrap", 8'(difficulty), 8'h02);
    tap(1'b0, 1'b1, 1'b0);
    check("dn_to_hard", 8'(difficulty), 8'h01);

    // Bounce: 3 low, 1 high, 2 low never reaches D stable samples.
    drive(1'b1, 1'b0, 1'b0); tick(3);
    drive(1'b0, 1'b0, 1'b0); tick(1);
    drive(1'b1, 1'b0, 1'b0); tick(2);
    drive(1'b0, 1'b0, 1'b0); tick(D + 6);
    check("bounce", 8'(difficulty), 8'h01);
    drive(1'b1, 1'b0, 1'b0); tick(6);
    drive(1'b0, 1'b0, 1'b0); tick(D + 6);
    check("bounce_then_hold", 8'(difficulty), 8'h02);

    // Up and down together cancel.
    tap(1'b1, 1'b1, 1'b0);
    check_state("up_dn_same", 2'b10, 1'b0, 1'b0);
    tap(1'b0, 1'b1, 1'b0);
    check("back_to_hard", 8'(difficulty), 8'h01);

    // Up and confirm together at HARD: confirm wins.
    drive(1'b1, 1'b0, 1'b1);
    tick(D + 3);
    check_state("cf_before", 2'b01, 1'b0, 1'b0);
    tick(1);
    check_state("cf_lock", 2'b01, 1'b1, 1'b1);
    tick(1);
    check_state("cf_pulse_end", 2'b01, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    tick(D + 6);

    // Presses ignored while locked.
    tap(1'b1, 1'b0, 1'b0);
    check_state("locked_up", 2'b01, 1'b1, 1'b0);
    tap(1'b0, 1'b0, 1'b1);
    check_state("locked_cf", 2'b01, 1'b1, 1'b0);

    // game_over unlocks the next cycle and keeps difficulty.
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    check_state("unlock", 2'b01, 1'b0, 1'b0);
    tap(1'b1, 1'b0, 1'b0);
    check("after_unlock_up", 8'(difficulty), 8'h02);

    // game_over in SELECT has no effect.
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    tick(2);
    check_state("go_in_select", 2'b10, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/difficulty_select.md
# difficulty_select

Upstream control stage for the difficulty display. Samples three raw active-low push-buttons (up, down, confirm), synchronises and debounces them, and steps a 2-bit difficulty code through EASY → HARD → HELL with wrap-around. Confirm locks the choice and fires a one-cycle game-start pulse. `difficulty` drives the seven-segment difficulty display directly; `start_pulse` and `locked` go to game control.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronised samples required to accept a level change (10 ms at 50 MHz); legal range 2..2^20.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `clk` input, 1 bit: system clock; all state on its rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `key_up_n` input, 1 bit: raw, asynchronous, active-low "next difficulty" button.
- `key_down_n` input, 1 bit: raw, asynchronous, active-low "previous difficulty" button.
- `key_confirm_n` input, 1 bit: raw, asynchronous, active-low lock button.
- `game_over` input, 1 bit: synchronous one-cycle pulse from game control; unlocks selection.
- `difficulty` output, 2 bits: 00 EASY, 01 HARD, 10 HELL; 11 never driven.
- `locked` output, 1 bit: high while the selection is frozen.
- `start_pulse` output, 1 bit: one-cycle pulse on the cycle `locked` rises.

## Operation
- Per-key chain: 2-FF synchroniser → debouncer → press detector.
- Filtered level resets to 1 (released).
- Debouncer counter:
  - Clears whenever synchronised level equals filtered level.
  - Otherwise increments each cycle.
  - When the counter equals DEBOUNCE_CYCLES−1 and the levels still differ, filtered takes the synchronised level and the counter clears.
- Press pulse is registered: high for exactly one cycle after a filtered 1→0 transition. Releases produce no pulse.
- FSM states:
  - SELECT (reset state).
  - LOCKED.
- In SELECT, with registered pulses up_p, dn_p, cf_p:
  - cf_p: enter LOCKED, assert `start_pulse`, `difficulty` held. up_p/dn_p are ignored that cycle (confirm wins).
  - up_p only: 00→01→10→00.
  - dn_p only: 00→10→01→00.
  - up_p and dn_p together: no change.
- In LOCKED:
  - All key pulses are ignored; debouncers keep running so held keys do not re-trigger after unlock.
  - `game_over` returns the FSM to SELECT and retains `difficulty`.
- `game_over` in SELECT is ignored.
- Reset values: `difficulty` = 00, `locked` = 0, `start_pulse` = 0, FSM = SELECT, all counters 0, synchronisers and filtered levels 1.
- Reset mid-debounce discards the partial count; a key held through reset release is re-qualified from zero and then generates one press.

## Timing
- Edge 0: raw key low first captured by sync stage 1.
- Edge 1: sync stage 2 low.
- Edges 2..D: counter reaches D−1, where D = DEBOUNCE_CYCLES.
- Edge D+1: filtered low.
- Edge D+2: press pulse high.
- Edge D+3: `difficulty`/`locked`/`start_pulse` updated.
- Total latency from raw press to output: D+3 edges after edge 0.
- A glitch shorter than D synchronised cycles produces no pulse.
- `start_pulse` is high for exactly one cycle, coincident with the first cycle `locked` = 1.
- `game_over` sampled at edge N gives `locked` = 0 after edge N; a key pulse at edge N+1 is honoured.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `game_pkg`:
  - Difficulty localparams DIFF_EASY = 2'b00, DIFF_HARD = 2'b01, DIFF_HELL = 2'b10.
  - FSM state encoding ST_SELECT / ST_LOCKED.
  - Shared with the display and game-control blocks.
- Sub-module `key_debounce`, one instance per key:
  - Synchroniser, counter, filtered level and registered press pulse.
  - Parameters DEBOUNCE_CYCLES, CNT_W.
- Top level holds the FSM and the difficulty register only.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: hold `rst_n` = 0 for 3 cycles with keys pressed, then release → `difficulty` = 00, `locked` = 0, `start_pulse` = 0; one press registers after requalification.
- Single clean press: `key_up_n` low from edge 0, held 10 cycles → `difficulty` 00→01 after edge 7; no further change while held or on release.
- Wrap both ways: 3 ups → 01, 10, 00. Then 1 down → 10.
- Bounce: `key_up_n` low 3 cycles, high 1 cycle, low 2 cycles, then high → no change. Finally held ≥ 6 cycles → exactly one increment.
- Simultaneous events:
  - up and down pulses in the same cycle → `difficulty` unchanged.
  - up and confirm in the same cycle at HARD → `locked` = 1, `difficulty` = 01, `start_pulse` high one cycle.
- Lock/unlock:
  - In LOCKED, up presses leave `difficulty` = 01.
  - `game_over` pulse → `locked` = 0 next cycle, `difficulty` still 01.
  - A subsequent up → 10.
  - `game_over` while in SELECT → no effect.
